// File: rtl/pipe_drain_buffer.sv
// Credit-returning receive FIFO at the tail of a fixed-latency pipeline; first-word fall-through, write-to-O 1 cycle, credit 1 cycle after pop.
// Backpressure via O_ready; words arriving while full with no pop are dropped (optional sticky flag under PIPE_DRAIN_BUFFER_OVF_CHECK_EN).
module pipe_drain_buffer #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 6
) (
    input  logic                         CLK,
    input  logic                         ASYNCRESETN,
    input  logic [WIDTH-1:0]             I,
    input  logic                         I_valid,
    output logic [WIDTH-1:0]             O,
    output logic                         O_valid,
    input  logic                         O_ready,
    output logic                         credit,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
        $error("pipe_drain_buffer: DEPTH must be in 2..256");
    end
    // The credit round trip is LATENCY+1 cycles, so a shallower FIFO starves the sender.
    if (DEPTH < LATENCY + 1) begin : g_rate_limited
        $warning("pipe_drain_buffer: DEPTH < LATENCY+1, throughput below one word per cycle");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             push;
    logic             pop;

    assign full    = (cnt == CW'(DEPTH));
    assign O_valid = (cnt != '0);
    assign O       = mem[rd_ptr];
    assign count   = cnt;
    assign pop     = O_valid && O_ready;
    // A pop frees the slot this same edge, so a full buffer still accepts.
    assign push    = I_valid && (!full || pop);

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= I;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            credit <= 1'b0;
        end else begin
            credit <= pop;
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef PIPE_DRAIN_BUFFER_OVF_CHECK_EN
    logic ovf_q;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            ovf_q <= 1'b0;
        end else if (I_valid && full && !pop) begin
            ovf_q <= 1'b1;
`ifndef SYNTHESIS
            $error("pipe_drain_buffer: word dropped, buffer full (upstream exceeded its credits)");
`endif
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: doc/pipe_drain_buffer.md
# pipe_drain_buffer

Receive-side buffer at the far end of a fixed-latency register-chain pipeline (LATENCY stages of WIDTH-bit registers). It captures every word leaving the last stage, holds it in a DEPTH-entry FIFO, and presents it downstream with a valid/ready handshake. Each word consumed downstream returns one credit upstream, so a sender that starts with DEPTH credits can never overrun the buffer, even with LATENCY cycles of words in flight.

## Interface
Parameters:
- WIDTH, 4, data word width in bits
- DEPTH, 8, FIFO entries; legal range 2..256; DEPTH equal to the upstream credit pool; DEPTH >= LATENCY+1 required for full throughput
- LATENCY, 6, upstream pipeline stages; documentation/assertion only, no datapath effect

Ports:
- CLK  input  1  clock, rising edge
- ASYNCRESETN  input  1  reset, asynchronous assert, active-low, synchronous deassert by the integrator
- I  input  WIDTH  word from the last pipeline stage
- I_valid  input  1  I carries a word this cycle
- O  output  WIDTH  head-of-FIFO word
- O_valid  output  1  FIFO non-empty
- O_ready  input  1  downstream accepts O this cycle
- credit  output  1  one-cycle pulse; one credit returned upstream
- count  output  clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky error flag (see Configuration)

## Operation
- Storage: DEPTH×WIDTH array, write pointer, read pointer, occupancy counter; pointers wrap DEPTH-1 -> 0 for any DEPTH, including non-power-of-2.
- push = I_valid && (count < DEPTH || pop); pop = O_valid && O_ready.
- Full and push in the same cycle as pop: accepted; count unchanged; both pointers advance.
- Empty with I_valid: word written; no combinational bypass to O.
- I_valid while full and no pop: word dropped; pointers and count unchanged.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- O = array[rd_ptr], first-word fall-through; O_valid = (count != 0). O is undefined-but-stable when O_valid=0; the bench must not check it.
- credit: registered copy of pop, so exactly one pulse per consumed word.
- Reset values: O_valid 0, count 0, credit 0, overflow 0, pointers 0. Array contents are not reset.
- Reset mid-operation: all state clears immediately. Buffered words and any pending credit pulse are lost. Upstream must reset its credit pool together with this block.

## Timing
- Write latency: a word pushed at edge N is visible on O with O_valid=1 after edge N, i.e. in cycle N+1.
- Pop at edge N: credit is high for cycle N+1 only.
- Sustained throughput: one word per cycle in and out simultaneously at any occupancy 1..DEPTH.
- Credit loop: upstream sees credit LATENCY+1 cycles before a new word can arrive at I, so DEPTH >= LATENCY+1 sustains 100% rate.
- No combinational path from O_ready to O_valid or O. The only combinational path is from O_ready to the push decision when full.

## Configuration
- PIPE_DRAIN_BUFFER_OVF_CHECK_EN defined:
  - overflow sets at the edge where I_valid=1, count==DEPTH and pop=0.
  - overflow holds until ASYNCRESETN.
  - A simulation-only error message prints on that event.
- Not defined: overflow is tied to 0, there is no detection logic, and the word is still dropped silently.

## Test plan
- Reset then idle: ASYNCRESETN low, then high, with I_valid=0 for 10 cycles -> O_valid=0, count=0, credit=0, overflow=0 throughout.
- Single word: I=4'hA, I_valid=1 for one cycle, O_ready=0 -> next cycle O_valid=1, O=4'hA, count=1. Raise O_ready for one cycle -> count=0 and credit high for exactly the following cycle.
- Fill and order, DEPTH=8: push 0x1..0x8 with O_ready=0 -> count=8. Then O_ready=1 -> O reads 0x1..0x8 in order, 8 credit pulses, O_valid drops after the 8th.
- Full with simultaneous push/pop: count=8, I=4'hF with I_valid=1 and O_ready=1 -> count stays 8, 4'hF emerges last, overflow=0.
- Overflow (macro defined): count=8, O_ready=0, I_valid=1 with I=4'h3 -> overflow=1 and sticky; 4'h3 never appears on O. With the macro undefined, overflow stays 0.
- Reset mid-stream: count=5, ASYNCRESETN pulsed low mid-cycle -> O_valid, count, credit and overflow are 0 immediately, before the next clock edge.
